avalon_slave_regfile: RTL and testbench

Avalon MM slave responder with fixed (non-waitrequest) timing: the counterpart that an avalon_master instruction table drives during simulation and hardware bring-up.
- Holds a small register file.
- Drives register 0 onto an I/O output port.
- Returns an external input word at the top register index.
- Sits behind the master's chipselect/read/write/address/writedata bus and returns readdata with a parameterised read latency.

---
 rtl/avalon_slave_regfile.sv | 184 ++++++++++++++++++
 tb/tb_avalon_slave_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_slave_regfile.sv
// Avalon-MM slave register file with fixed wait/latency timing, io_out mirror of reg 0,
// and io_in visible at the top index. Optional access counters: AVSLAVE_ACCESS_COUNT_EN.
module avalon_slave_regfile #(
  parameter int ADDR_SIZE    = 32,
  parameter int DATA_SIZE    = 32,
  parameter int REG_IDX_SIZE = 3,
  parameter int READ_WAIT    = 1,
  parameter int WRITE_WAIT   = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 avslave_chipselect,
  input  logic                 avslave_read,
  input  logic                 avslave_write,
  input  logic [ADDR_SIZE-1:0] avslave_address,
  input  logic [DATA_SIZE-1:0] avslave_writedata,
  output logic [DATA_SIZE-1:0] avslave_readdata,
  output logic                 avslave_readdatavalid,
  output logic [DATA_SIZE-1:0] io_out,
  input  logic [DATA_SIZE-1:0] io_in,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);

  localparam int NREG = 1 << REG_IDX_SIZE;
  localparam int AW   = (ADDR_SIZE > REG_IDX_SIZE) ? ADDR_SIZE : REG_IDX_SIZE + 1;
  localparam logic [REG_IDX_SIZE-1:0] TOP_IDX = REG_IDX_SIZE'(NREG - 1);

  // state      | meaning
  // ST_IDLE    | waiting for a clean read or write strobe
  // ST_WR_WAIT | write held, counting down wait cycles before commit
  // ST_WR_DONE | write committed, waiting for write strobe to drop
  // ST_RD_WAIT | read held, counting down wait cycles before acceptance
  // ST_RD_LAT  | read accepted, counting latency; bus ignored
  // ST_RD_DONE | readdata delivered, waiting for read strobe to drop
  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_WAIT, ST_WR_DONE, ST_RD_WAIT, ST_RD_LAT, ST_RD_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            lat_q, lat_d;
  logic [DATA_SIZE-1:0]  pend_q, pend_d;
  logic [DATA_SIZE-1:0]  rdata_q, rdata_d;
  logic                  rdv_q, rdv_d;
  logic [DATA_SIZE-1:0]  regs_q [NREG];
  logic [DATA_SIZE-1:0]  regs_d [NREG];
  logic                  commit;

  logic                    rd_act, wr_act;
  logic [AW-1:0]           addr_ext;
  logic                    addr_oor;
  logic [REG_IDX_SIZE-1:0] idx;
  logic [DATA_SIZE-1:0]    rd_word;

  assign rd_act   = avslave_chipselect & avslave_read & ~avslave_write;
  assign wr_act   = avslave_chipselect & avslave_write & ~avslave_read;
  assign addr_ext = AW'(avslave_address);
  assign addr_oor = |addr_ext[AW-1:REG_IDX_SIZE];
  assign idx      = addr_ext[REG_IDX_SIZE-1:0];

  always_comb begin
    rd_word = '0;
    if (!addr_oor) rd_word = (idx == TOP_IDX) ? io_in : regs_q[idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    pend_d  = pend_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    regs_d  = regs_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_act) begin
          if (WRITE_WAIT == 0) begin
            commit  = 1'b1;
            state_d = ST_WR_DONE;
          end else begin
            cnt_d   = 8'(WRITE_WAIT - 1);
            state_d = ST_WR_WAIT;
          end
        end else if (rd_act) begin
          if (READ_WAIT == 0) begin
            pend_d  = rd_word;
            lat_d   = 8'(READ_LATENCY - 1);
            state_d = ST_RD_LAT;
          end else begin
            cnt_d   = 8'(READ_WAIT - 1);
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_WR_WAIT: begin
        if (!wr_act) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          commit  = 1'b1;
          state_d = ST_WR_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WR_DONE: begin
        if (!avslave_write) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (!rd_act) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          pend_d  = rd_word;
          lat_d   = 8'(READ_LATENCY - 1);
          state_d = ST_RD_LAT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RD_LAT: begin
        if (lat_q == 8'd0) begin
          rdata_d = pend_q;
          rdv_d   = 1'b1;
          state_d = ST_RD_DONE;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      ST_RD_DONE: begin
        if (!avslave_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The top index is read-only status; out-of-range writes still complete the handshake.
    if (commit && !addr_oor && idx != TOP_IDX) regs_d[idx] = avslave_writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      regs_q  <= regs_d;
    end
  end

  assign avslave_readdata      = rdata_q;
  assign avslave_readdatavalid = rdv_q;
  assign io_out                = regs_q[0];

`ifdef AVSLAVE_ACCESS_COUNT_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (commit) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rdv_d)  rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  assign wr_count = 16'h0;
  assign rd_count = 16'h0;
`endif

endmodule

// File: tb/tb_avalon_slave_regfile.sv
// Directed bench for avalon_slave_regfile: vector table of writes/reads plus
// hand sequences for write abort, read abort, write during latency and reset mid-read.
module tb_avalon_slave_regfile;

  localparam int RW    = 1;
  localparam int WW    = 1;
  localparam int RL    = 2;
  localparam int EXP_K = RW + 1 + RL;
  localparam logic [31:0] IO_IN_VAL = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, rd, wr;
  logic [31:0] address, wdata;
  logic [31:0] rdata, io_out, io_in;
  logic        rdv;
  logic [15:0] wr_count, rd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;

  always #5 clk = ~clk;

  avalon_slave_regfile #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .REG_IDX_SIZE(3),
    .READ_WAIT(RW), .WRITE_WAIT(WW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avslave_chipselect(cs),
    .avslave_read(rd),
    .avslave_write(wr),
    .avslave_address(address),
    .avslave_writedata(wdata),
    .avslave_readdata(rdata),
    .avslave_readdatavalid(rdv),
    .io_out(io_out),
    .io_in(io_in),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // io_out after a write, readdata for a read
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef AVSLAVE_ACCESS_COUNT_EN
    return {16'h0, 16'(n)};
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_wr_count"}, {16'h0, wr_count}, cnt_exp(exp_wr));
    check({tag, "_rd_count"}, {16'h0, rd_count}, cnt_exp(exp_rd));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; address = a; wdata = d;
    repeat (hold) @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    int  k;
    bit  seen;
    logic [31:0] got;
    cs = 1'b1; rd = 1'b1; wr = 1'b0; address = a;
    k = 0; seen = 1'b0; got = 'x;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (rdv) begin
        seen = 1'b1;
        got  = rdata;
      end
    end
    cs = 1'b0; rd = 1'b0;
    exp_rd++;
    check({name, "_latency"}, 32'(k), 32'(EXP_K));
    check({name, "_data"}, got, exp);
    @(negedge clk);
    check({name, "_rdv_pulse"}, {31'b0, rdv}, 32'h0);
    check({name, "_data_hold"}, rdata, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_rdv;
    logic [31:0] rd_seen;

    vecs[0]  = '{1'b1, 32'h0,   32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h2,   32'h12345678, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h2,   32'h0,        32'h12345678};
    vecs[3]  = '{1'b1, 32'h7,   32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 32'h100, 32'h55555555, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'h7,   32'h0,        32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 32'h100, 32'h0,        32'h00000000};
    vecs[7]  = '{1'b0, 32'h102, 32'h0,        32'h00000000};
    vecs[8]  = '{1'b1, 32'h5,   32'hCAFEF00D, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 32'h5,   32'h0,        32'hCAFEF00D};
    vecs[10] = '{1'b0, 32'h0,   32'h0,        32'hDEADBEEF};
    vecs[11] = '{1'b1, 32'h1,   32'h0BADC0DE, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 32'h1,   32'h0,        32'h0BADC0DE};

    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    address = '0; wdata = '0; io_in = IO_IN_VAL;
    repeat (3) @(negedge clk);
    check("reset_readdata", rdata, 32'h0);
    check("reset_rdv", {31'b0, rdv}, 32'h0);
    check("reset_io_out", io_out, 32'h0);
    check_counts("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, WW + 1);
        exp_wr++;
        check($sformatf("vec%0d_io_out", i), io_out, vecs[i].exp);
      end else begin
        do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_read", i));
      end
      check_counts($sformatf("vec%0d", i));
    end

    // Write held for one cycle only never reaches its commit edge.
    do_write(32'h0, 32'h11111111, 1);
    @(negedge clk);
    check("wr_abort_io_out", io_out, 32'hDEADBEEF);
    check_counts("wr_abort");
    do_read(32'h0, 32'hDEADBEEF, "wr_abort_readback");

    // Read held for one cycle only is dropped without a pulse.
    cs = 1'b1; rd = 1'b1; address = 32'h2;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    n_rdv = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdv) n_rdv++;
    end
    check("rd_abort_no_pulse", 32'(n_rdv), 32'h0);
    check_counts("rd_abort");

    // Write to the same register while a read is in latency.
    cs = 1'b1; rd = 1'b1; address = 32'h2;
    repeat (2) @(negedge clk);
    rd = 1'b0; wr = 1'b1; wdata = 32'h00000001;
    n_rdv = 0; rd_seen = '0;
    repeat (5) begin
      @(negedge clk);
      if (rdv) begin
        n_rdv++;
        rd_seen = rdata;
      end
    end
    cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    exp_rd++;
    exp_wr++;
    check("lat_wr_pulses", 32'(n_rdv), 32'h1);
    check("lat_wr_old_data", rd_seen, 32'h12345678);
    check_counts("lat_wr");
    do_read(32'h2, 32'h00000001, "lat_wr_readback");

    // Reset while a read is in latency drops it.
    cs = 1'b1; rd = 1'b1; address = 32'h2;
    repeat (2) @(negedge clk);
    reset = 1'b1; cs = 1'b0; rd = 1'b0;
    #1;
    check("rst_lat_readdata", rdata, 32'h0);
    check("rst_lat_rdv", {31'b0, rdv}, 32'h0);
    check("rst_lat_io_out", io_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n_rdv = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdv) n_rdv++;
    end
    check("rst_lat_no_pulse", 32'(n_rdv), 32'h0);
    exp_wr = 0;
    exp_rd = 0;
    check_counts("rst_lat");
    do_read(32'h2, 32'h0, "rst_lat_reg2");
    do_read(32'h7, IO_IN_VAL, "rst_lat_io_in");
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
